// File: rtl/uart_mode_commander.sv
// uart_mode_commander
//   Host-side initiator for the UART mode-change handshake. On a controller
//   request it sends the sync byte 0xFF and checks its echo. It then sends
//   {4'hF, mode} and waits until that byte has fully left the local TX.
//   Next it switches the local TX/RX mode and checks the echo at the new mode.
//   Each accepted request ends with exactly one done or err pulse, unless
//   reset aborts it.
//
// Parameters
//   INIT_MODE       local_mode after reset (responder power-up mode)
//   TIMEOUT_CYCLES  max clk cycles spent waiting for each echo byte (>= 2)
//   TO_W            timeout counter width, must hold TIMEOUT_CYCLES
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   req_valid/req_mode      mode-change request from the controller
//   req_ready               high only while idle
//   tx_data/tx_valid        byte offered to the local TX
//   tx_ready                local TX able to accept; drops while shifting
//   rx_data/rx_valid        received byte strobe from the local RX
//   local_mode              mode driven to the local TX/RX instances
//   busy                    high whenever a request is in progress
//   done/err                one-cycle completion pulses
//   err_code                1=timeout, 2=echo mismatch, 0=none; held until
//                           the next accepted request
module uart_mode_commander #(
  parameter logic [3:0]  INIT_MODE      = 4'd1,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned TO_W           = 22
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [3:0] req_mode,
  output logic       req_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [3:0] local_mode,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_SYNC,
    WAIT_SYNC_ECHO,
    SEND_MODE,
    WAIT_TX_DONE,
    WAIT_MODE_ECHO
  } state_t;

  localparam logic [7:0]      SYNC_BYTE    = 8'hFF;
  localparam logic [1:0]      ERR_NONE     = 2'd0;
  localparam logic [1:0]      ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0]      ERR_MISMATCH = 2'd2;
  localparam logic [TO_W-1:0] TO_LAST      = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [3:0]      mode_q;
  logic [TO_W-1:0] to_cnt;
  logic            seen_low;
  logic            timed_out;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign timed_out = (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mode_q     <= INIT_MODE;
      to_cnt     <= '0;
      seen_low   <= 1'b0;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      local_mode <= INIT_MODE;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            mode_q   <= req_mode;
            err_code <= ERR_NONE;
            state    <= SEND_SYNC;
          end
        end

        // tx_valid is raised only once tx_ready is seen, then held with stable
        // data until the transfer cycle.
        SEND_SYNC: begin
          if (tx_valid) begin
            if (tx_ready) begin
              tx_valid <= 1'b0;
              to_cnt   <= '0;
              state    <= WAIT_SYNC_ECHO;
            end
          end else if (tx_ready) begin
            tx_valid <= 1'b1;
            tx_data  <= SYNC_BYTE;
          end
        end

        // rx_valid is checked before the timeout, so an echo arriving on the
        // terminal cycle still counts.
        WAIT_SYNC_ECHO: begin
          if (rx_valid) begin
            if (rx_data == SYNC_BYTE) begin
              state <= SEND_MODE;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_MISMATCH;
              state    <= IDLE;
            end
          end else if (timed_out) begin
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            state    <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        SEND_MODE: begin
          if (tx_valid) begin
            if (tx_ready) begin
              tx_valid <= 1'b0;
              seen_low <= 1'b0;
              state    <= WAIT_TX_DONE;
            end
          end else if (tx_ready) begin
            tx_valid <= 1'b1;
            tx_data  <= {4'hF, mode_q};
          end
        end

        // A low-then-high tx_ready means the mode byte has fully shifted out
        // at the old mode. Only then is it safe to retune the local UART.
        WAIT_TX_DONE: begin
          if (!tx_ready) begin
            seen_low <= 1'b1;
          end else if (seen_low) begin
            local_mode <= mode_q;
            to_cnt     <= '0;
            state      <= WAIT_MODE_ECHO;
          end
        end

        // local_mode stays at mode_q on failure: the responder has already
        // switched.
        WAIT_MODE_ECHO: begin
          if (rx_valid) begin
            if (rx_data == {4'hF, mode_q}) begin
              done <= 1'b1;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_MISMATCH;
            end
            state <= IDLE;
          end else if (timed_out) begin
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            state    <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mode_commander.sv
// Testbench for uart_mode_commander. The stimulus process issues requests.
// For each request it pushes the expected TX bytes and the expected outcome
// into queues. A TX/echo model stands in for the local UART and the
// board-side responder. A separate monitor pops and compares on every TX
// transfer and every done/err pulse.
module tb_uart_mode_commander;

  localparam int unsigned TO   = 50;
  localparam logic [3:0]  INIT = 4'd1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [3:0] req_mode = 4'h0;
  logic       req_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] local_mode;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  uart_mode_commander #(
    .INIT_MODE      (INIT),
    .TIMEOUT_CYCLES (TO),
    .TO_W           (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_mode   (req_mode),
    .req_ready  (req_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .local_mode (local_mode),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  int unsigned cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit         is_err;
    logic [1:0] code;
    logic [3:0] mode;
    bit         chk_time;
  } res_t;

  logic [7:0]  exp_tx[$];
  res_t        exp_res[$];
  int unsigned last_ff_edge = 0;
  logic [3:0]  cur_mode = INIT;

  // Echo behaviour per byte: 0 = faithful echo, 1 = corrupted, 2 = no echo
  int         sync_kind = 0;
  int         mode_kind = 0;
  logic [7:0] corrupt_x = 8'h01;
  int         req_id    = 0;
  bit         noise_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Local TX plus echoing responder. Also injects stray 0x55 bytes when told
  // that the commander is idle.
  initial begin : tx_model
    int         seen_id;
    int         idx;
    int         k;
    logic [7:0] b;
    seen_id  = -1;
    idx      = 0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    wait (!reset);
    repeat (10) @(posedge clk);
    #1 tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      rx_valid = 1'b0;
      if (!reset && tx_valid && tx_ready) begin
        if (seen_id != req_id) begin
          seen_id = req_id;
          idx     = 0;
        end
        b = tx_data;
        k = (idx == 0) ? sync_kind : mode_kind;
        idx++;
        @(posedge clk);
        #1 tx_ready = 1'b0;
        repeat ($urandom_range(3, 10)) @(posedge clk);
        #1 tx_ready = 1'b1;
        if (k != 2) begin
          repeat ($urandom_range(2, 20)) @(posedge clk);
          #1;
          rx_data  = (k == 0) ? b : (b ^ corrupt_x);
          rx_valid = 1'b1;
          @(posedge clk);
          #1 rx_valid = 1'b0;
        end
      end else if (noise_en && $urandom_range(0, 3) == 0) begin
        rx_data  = 8'h55;
        rx_valid = 1'b1;
      end
    end
  end

  // Scoreboard monitor
  initial begin : monitor
    res_t r;
    logic [7:0] eb;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (tx_valid)
          check("tx_valid_only_when_busy", busy, 1);
        if (tx_valid && tx_ready) begin
          if (exp_tx.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL tx_unexpected: got byte 0x%0h expected no transfer", tx_data);
          end else begin
            eb = exp_tx.pop_front();
            check("tx_byte", tx_data, eb);
            if (eb == 8'hFF)
              last_ff_edge = cycle + 1;
          end
        end
        if (done || err) begin
          check("done_err_exclusive", done && err, 0);
          check("req_ready_with_pulse", req_ready, 1);
          if (exp_res.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL result_unexpected: got done=%0b err=%0b expected no pulse", done, err);
          end else begin
            r = exp_res.pop_front();
            check("result_is_err", err, r.is_err);
            check("err_code", err_code, r.code);
            check("local_mode_at_end", local_mode, r.mode);
            if (r.chk_time)
              check("timeout_latency", cycle - last_ff_edge, TO);
          end
        end
      end
    end
  end

  // Reference model: derive the expected bytes and outcome from the
  // scenario, then drive the request.
  task automatic issue(input logic [3:0] m, input int sk, input int mk,
                       input logic [7:0] cx, input bit abort);
    res_t r;
    sync_kind = sk;
    mode_kind = mk;
    corrupt_x = cx;
    req_id++;
    exp_tx.push_back(8'hFF);
    if (sk == 0) begin
      exp_tx.push_back({4'hF, m});
      cur_mode   = m;
      r.mode     = m;
      r.is_err   = (mk != 0);
      r.code     = (mk == 0) ? 2'd0 : (mk == 1) ? 2'd2 : 2'd1;
      r.chk_time = 1'b0;
    end else begin
      r.mode     = cur_mode;
      r.is_err   = 1'b1;
      r.code     = (sk == 1) ? 2'd2 : 2'd1;
      r.chk_time = (sk == 2);
    end
    if (!abort)
      exp_res.push_back(r);
    @(negedge clk);
    noise_en = 1'b0;
    check("req_ready_idle", req_ready, 1);
    req_mode  = m;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait for the pulse while poking req_valid during busy. Afterwards leave
  // an idle gap with stray RX bytes.
  task automatic wait_end();
    int n;
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (done || err) break;
      if (busy && $urandom_range(0, 7) == 0) begin
        req_mode  = 4'($urandom);
        req_valid = 1'b1;
      end
    end
    if (n == 400) begin
      checks++;
      failures++;
      $display("FAIL completion_wait: got no done/err within 400 cycles expected a pulse");
    end
    noise_en = 1'b1;
    repeat ($urandom_range(2, 8)) @(negedge clk);
  endtask

  task automatic reset_and_check(input string tag);
    @(negedge clk);
    reset = 1'b1;
    exp_tx.delete();
    exp_res.delete();
    cur_mode = INIT;
    @(negedge clk);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_local_mode"}, local_mode, INIT);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_done_err"}, {done, err}, 0);
    check({tag, "_err_code"}, err_code, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : stimulus
    int n;
    int sk;
    int mk;
    repeat (2) @(negedge clk);
    check("reset_tx_data", tx_data, 8'h00);
    reset_and_check("reset");

    // Happy path
    issue(4'h3, 0, 0, 8'h00, 0);
    wait_end();
    // Sync echo 0xFE
    issue(4'h5, 1, 0, 8'h01, 0);
    wait_end();
    // Sync echo missing
    issue(4'h6, 2, 0, 8'h00, 0);
    wait_end();
    // Mode echo F5 for request 2
    issue(4'h2, 0, 1, 8'h07, 0);
    wait_end();
    // Mode echo missing
    issue(4'h9, 0, 2, 8'h00, 0);
    wait_end();

    // Reset while waiting for the mode echo, then a normal request
    issue(4'h7, 0, 2, 8'h00, 1);
    for (n = 0; n < 200 && local_mode != 4'h7; n++) @(negedge clk);
    check("abort_reached_mode_wait", local_mode, 4'h7);
    repeat (5) @(negedge clk);
    reset_and_check("abort");
    issue(4'h4, 0, 0, 8'h00, 0);
    wait_end();

    // Same mode as current still runs the full sequence
    issue(4'h4, 0, 0, 8'h00, 0);
    wait_end();

    for (int i = 0; i < 40; i++) begin
      n  = $urandom_range(0, 9);
      sk = (n < 8) ? 0 : (n - 7);
      n  = $urandom_range(0, 9);
      mk = (n < 8) ? 0 : (n - 7);
      issue(4'($urandom_range(0, 15)), sk, mk, 8'($urandom_range(1, 255)), 0);
      wait_end();
    end

    noise_en = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_res.size() + exp_tx.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
